// File: rtl/firc_accum.sv
// firc_accum -- output accumulation stage of the 29-tap complex FIR.
//
// Sums the NPROD complex products delivered each cycle. Then accumulates
// those sums over the first/middle/last tap-group phases of a sample. The
// total is rounded (half toward +inf), shifted right by SHIFT and presented
// on FI/FQ with a one-cycle PushOut pulse.
//
// Configuration macro: FIRC_ACC_SAT_EN
//   defined   : an out-of-range result is clamped to the OW-bit signed limits
//   undefined : the output is the low OW bits of the result (wrap)
//   Ovf is raised for an out-of-range result in both builds.
//
// Ports:
//   Clk        in   clock, rising-edge
//   Reset      in   synchronous active-high reset
//   ProdValid  in   product buses valid this cycle
//   ProdFirst  in   first phase of a sample
//   ProdLast   in   last phase of a sample (may coincide with ProdFirst)
//   ProdI      in   NPROD*PW packed signed real parts, product k at [PW*k +: PW]
//   ProdQ      in   NPROD*PW packed signed imaginary parts
//   PushOut    out  one-cycle pulse: FI/FQ carry a new result
//   FI, FQ     out  OW-bit filtered result, held between pulses
//   Ovf        out  sticky: a result exceeded the OW-bit signed range
//   SeqErr     out  sticky: illegal First/Last sequencing seen
//
// Pipeline: S1 (product sum) -> accumulator -> output register, 3 cycles.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no sample open; next valid phase must carry First
// ACC   | sample open; middle/last phases add into the accumulator

module firc_accum #(
    parameter int NPROD = 5,
    parameter int PW    = 54,
    parameter int AW    = 60,
    parameter int SHIFT = 24,
    parameter int OW    = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ProdValid,
    input  logic                ProdFirst,
    input  logic                ProdLast,
    input  logic [NPROD*PW-1:0] ProdI,
    input  logic [NPROD*PW-1:0] ProdQ,
    output logic                PushOut,
    output logic [OW-1:0]       FI,
    output logic [OW-1:0]       FQ,
    output logic                Ovf,
    output logic                SeqErr
);

    localparam int SW = PW + 3;             // sum of up to 8 products
    localparam int RW = AW + 1 - SHIFT;     // width of the shifted result
    localparam logic [AW:0] RND = (AW + 1)'(1) << (SHIFT - 1);

    typedef enum logic {IDLE, ACC} state_t;

    // ---------------- stage 1: product sum ----------------
    logic [SW-1:0] sum_i_d, sum_q_d;
    logic [SW-1:0] s1_i_q, s1_q_q;
    logic          s1_v_q, s1_f_q, s1_l_q;

    always_comb begin
        sum_i_d = '0;
        sum_q_d = '0;
        for (int k = 0; k < NPROD; k++) begin
            sum_i_d = sum_i_d + {{(SW-PW){ProdI[PW*k+PW-1]}}, ProdI[PW*k +: PW]};
            sum_q_d = sum_q_d + {{(SW-PW){ProdQ[PW*k+PW-1]}}, ProdQ[PW*k +: PW]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_i_q <= '0;
            s1_q_q <= '0;
            s1_v_q <= 1'b0;
            s1_f_q <= 1'b0;
            s1_l_q <= 1'b0;
        end else begin
            s1_i_q <= sum_i_d;
            s1_q_q <= sum_q_d;
            s1_v_q <= ProdValid;
            s1_f_q <= ProdFirst;
            s1_l_q <= ProdLast;
        end
    end

    // ---------------- stage 2: accumulator FSM ----------------
    state_t        state_q, state_d;
    logic [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic          emit_q, emit_d;
    logic          seq_err_q, seq_err_d;
    logic [AW-1:0] s1_i_ext, s1_q_ext;

    assign s1_i_ext = {{(AW-SW){s1_i_q[SW-1]}}, s1_i_q};
    assign s1_q_ext = {{(AW-SW){s1_q_q[SW-1]}}, s1_q_q};

    always_comb begin
        state_d   = state_q;
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        emit_d    = 1'b0;
        seq_err_d = seq_err_q;
        if (s1_v_q) begin
            case (state_q)
                IDLE: begin
                    if (s1_f_q) begin
                        acc_i_d = s1_i_ext;
                        acc_q_d = s1_q_ext;
                        if (s1_l_q) emit_d  = 1'b1;
                        else        state_d = ACC;
                    end else begin
                        // orphan continuation phase: flag and drop it
                        seq_err_d = 1'b1;
                    end
                end
                ACC: begin
                    if (s1_f_q) begin
                        // new sample before the old one closed: restart
                        seq_err_d = 1'b1;
                        acc_i_d   = s1_i_ext;
                        acc_q_d   = s1_q_ext;
                    end else begin
                        acc_i_d = acc_i_q + s1_i_ext;
                        acc_q_d = acc_q_q + s1_q_ext;
                    end
                    if (s1_l_q) begin
                        emit_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            emit_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            emit_q    <= emit_d;
            seq_err_q <= seq_err_d;
        end
    end

    // ---------------- stage 3: round, scale, range ----------------
    // One extra bit keeps the rounding add from wrapping at the top of range.
    logic [AW:0]   rnd_i, rnd_q;
    logic [RW-1:0] r_i, r_q;
    logic          ovf_i, ovf_q;
    logic [OW-1:0] out_i, out_q;

    assign rnd_i = {acc_i_q[AW-1], acc_i_q} + RND;
    assign rnd_q = {acc_q_q[AW-1], acc_q_q} + RND;
    assign r_i   = rnd_i[AW:SHIFT];
    assign r_q   = rnd_q[AW:SHIFT];

    // in range only if all bits from the OW-bit sign upward agree
    assign ovf_i = |r_i[RW-1:OW-1] && !(&r_i[RW-1:OW-1]);
    assign ovf_q = |r_q[RW-1:OW-1] && !(&r_q[RW-1:OW-1]);

`ifdef FIRC_ACC_SAT_EN
    assign out_i = !ovf_i ? r_i[OW-1:0] :
                   r_i[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    assign out_q = !ovf_q ? r_q[OW-1:0] :
                   r_q[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`else
    assign out_i = r_i[OW-1:0];
    assign out_q = r_q[OW-1:0];
`endif

    logic [OW-1:0] fi_q, fq_q;
    logic          push_q, ovf_sticky_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fi_q         <= '0;
            fq_q         <= '0;
            push_q       <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            push_q <= emit_q;
            if (emit_q) begin
                fi_q         <= out_i;
                fq_q         <= out_q;
                ovf_sticky_q <= ovf_sticky_q | ovf_i | ovf_q;
            end
        end
    end

    assign PushOut = push_q;
    assign FI      = fi_q;
    assign FQ      = fq_q;
    assign Ovf     = ovf_sticky_q;
    assign SeqErr  = seq_err_q;

endmodule
